// File: rtl/fifo_read_arb_pkg.sv
// Shared types, default parameters and sizing helper for the FIFO read arbiter.
package fifo_read_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_RD_LAT    = 1;

  function automatic int cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take lowest set bit,
// rotate the result back into absolute index space.
module rr_arb_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic [N_REQ-1:0] rot;
  logic [IW:0]      j;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  always_comb begin
    rot = '0;
    j   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = {1'b0, ptr_i} + (IW+1)'(i);
      if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
      rot[i] = req_i[j[IW-1:0]];
    end

    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end

    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    idx_o = sum[IW-1:0];
    gnt_o = (|req_i) ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter sharing one FIFO read port among N_REQ requesters.
// Optional FIFO_READ_ARB_PRIO0_EN: requester 0 pre-empts the rotation in IDLE.
module fifo_read_arbiter
  import fifo_read_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DW        = DEF_DW,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic             i_clk,
  input  logic             i_rest,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_empty,
  input  logic [DW-1:0]    i_rdata,
  output logic             o_ren,
  output logic [N_REQ-1:0] o_gnt,
  output logic [N_REQ-1:0] o_rvalid,
  output logic [DW-1:0]    o_rdata,
  output logic             o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(BURST_MAX);

  state_t                    state_q, state_d;
  logic [N_REQ-1:0]          gnt_q, gnt_d;
  logic [IW-1:0]             win_q, win_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [1:0]                dcnt_q, dcnt_d;
  logic                      ren;
  logic [N_REQ-1:0]          pick_gnt;
  logic [IW-1:0]             pick_idx;
  logic [RD_LAT-1:0]         pv_q;
  logic [RD_LAT-1:0][IW-1:0] pi_q;

  rr_arb_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    ren     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|i_req) && !i_empty) begin
          state_d = READ;
          cnt_d   = '0;
`ifdef FIFO_READ_ARB_PRIO0_EN
          if (i_req[0]) begin
            win_d = '0;
            gnt_d = N_REQ'(1);
          end else begin
            win_d = pick_idx;
            gnt_d = pick_gnt;
          end
`else
          win_d = pick_idx;
          gnt_d = pick_gnt;
`endif
        end
      end
      READ: begin
        // No read is launched while reset is asserted: its data would be discarded.
        ren = i_req[win_q] & ~i_empty & ~i_rest;
        if (ren) cnt_d = cnt_q + CW'(1);
        if (!ren || cnt_q == CW'(BURST_MAX - 1)) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'(RD_LAT - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef FIFO_READ_ARB_PRIO0_EN
          if (win_q != '0)
            ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
`else
          ptr_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
`endif
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Latency pipe: (read issued, owner index), RD_LAT stages deep.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      pv_q <= '0;
      pi_q <= '0;
    end else begin
      pv_q[0] <= ren;
      pi_q[0] <= win_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rvalid
      assign o_rvalid[gi] = pv_q[RD_LAT-1] & (pi_q[RD_LAT-1] == IW'(gi)) & ~i_rest;
    end
  endgenerate

  assign o_ren   = ren;
  assign o_gnt   = gnt_q;
  assign o_rdata = i_rdata;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Table-driven bench for fifo_read_arbiter (N_REQ=4, BURST_MAX=4, RD_LAT=1),
// with a scoreboard matching o_rvalid/o_rdata against expected reads.
module tb_fifo_read_arbiter;

  logic       i_clk;
  logic       i_rest;
  logic [3:0] i_req;
  logic       i_empty;
  logic [7:0] i_rdata;
  logic       o_ren;
  logic [3:0] o_gnt;
  logic [3:0] o_rvalid;
  logic [7:0] o_rdata;
  logic       o_busy;

  fifo_read_arbiter #(.N_REQ(4), .DW(8), .BURST_MAX(4), .RD_LAT(1)) dut (
    .i_clk    (i_clk),
    .i_rest   (i_rest),
    .i_req    (i_req),
    .i_empty  (i_empty),
    .i_rdata  (i_rdata),
    .o_ren    (o_ren),
    .o_gnt    (o_gnt),
    .o_rvalid (o_rvalid),
    .o_rdata  (o_rdata),
    .o_busy   (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       empty;
    logic [3:0] gnt;
    logic       ren;
    logic       busy;
  } vec_t;

  typedef struct {
    int         due;
    logic [3:0] gnt;
    logic [7:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic empty,
                     input logic [3:0] gnt, input logic ren, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.empty = empty;
    v.gnt = gnt; v.ren = ren; v.busy = busy;
    vecs.push_back(v);
  endtask

  // One full burst: IDLE arbitration cycle, 4 reads, 1 drain cycle.
  task automatic add_burst(input logic [3:0] req, input int w);
    logic [3:0] g;
    g = 4'b0001 << w;
    add(1'b0, req, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (4) add(1'b0, req, 1'b0, g, 1'b1, 1'b1);
    add(1'b0, req, 1'b0, g, 1'b0, 1'b1);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_rv;
    logic [7:0] exp_rd;

    i_rest  = 1'b1;
    i_req   = 4'b0000;
    i_empty = 1'b0;
    i_rdata = 8'h00;

    // Reset with all requesting: nothing granted.
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Full-burst rotation (prio build: requester 0 keeps winning).
    for (int b = 0; b < 5; b++) begin
`ifdef FIFO_READ_ARB_PRIO0_EN
      add_burst(4'b1111, 0);
`else
      add_burst(4'b1111, b % 4);
`endif
    end
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Empty stall after 2 reads, regrant only when not empty.
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Requester 1 drops after one read; next grant goes to 2.
    add(1'b0, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1);

    // Reset the cycle after the 2nd read; pointer must return to 0.
    add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1);
    add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1);
    add(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1);
    add(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Requester 0 idle: the others rotate 1 -> 2 -> 3.
    add_burst(4'b1110, 1);
    add_burst(4'b1110, 2);
    add_burst(4'b1110, 3);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge i_clk);
      i_rest  = vecs[i].rst;
      i_req   = vecs[i].req;
      i_empty = vecs[i].empty;
      i_rdata = 8'(cyc * 7 + 3);
      #1;
      $display("[TB] vec %0d rst=%b req=%b empty=%b gnt=%b ren=%b rvalid=%b busy=%b",
               i, i_rest, i_req, i_empty, o_gnt, o_ren, o_rvalid, o_busy);
      chk("gnt",  i, 8'(o_gnt),  8'(vecs[i].gnt));
      chk("ren",  i, 8'(o_ren),  8'(vecs[i].ren));
      chk("busy", i, 8'(o_busy), 8'(vecs[i].busy));

      if (vecs[i].rst) sbq.delete();
      exp_rv = 4'b0000;
      exp_rd = 8'h00;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_rv = sbq[0].gnt;
        exp_rd = sbq[0].data;
        void'(sbq.pop_front());
        chk("rdata", i, o_rdata, exp_rd);
      end
      chk("rvalid", i, 8'(o_rvalid), 8'(exp_rv));

      if (vecs[i].ren) begin
        sb_t e;
        e.due  = cyc + 1;
        e.gnt  = vecs[i].gnt;
        e.data = 8'((cyc + 1) * 7 + 3);
        sbq.push_back(e);
      end
      cyc++;
    end

    chk("sb_left", vecs.size(), 8'(sbq.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
